multicycle_controller: RTL and testbench

Sequencing FSM for the multicycle RV32I datapath. It steps one instruction at a time through fetch, decode, execute, memory and writeback. It drives the shared ALU, the shared instruction/data memory port and the register-file, PC and IR write enables, with a ready handshake to memory. It sits beside the datapath and replaces per-instruction single-cycle decode, taking `op` from the IR.

---
 rtl/multicycle_controller_if.sv | 47 ++++
 rtl/multicycle_controller.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller_if
// Description : Control bundle between the multicycle RV32I sequencer and its
//               datapath / memory port.
//   master (controller) inputs : op[6:0], branch_taken, mem_ready
//   master (controller) outputs: mem_req, AdrSrc, MemWrite, IRWrite,
//                                PCWrite, RegWrite, ResultSrc[1:0],
//                                ALUSrcA[1:0], ALUSrcB[1:0], ALUOp[1:0],
//                                ImmSrc[2:0], instr_done, illegal
//   slave (datapath) sees the same signals with directions reversed.
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_controller_if;
  // Datapath / memory -> controller
  logic [6:0] op;
  logic       branch_taken;
  logic       mem_ready;

  // Controller -> datapath / memory
  logic       mem_req;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [2:0] ImmSrc;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  op, branch_taken, mem_ready,
    output mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done, illegal
  );

  modport slave (
    output op, branch_taken, mem_ready,
    input  mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done, illegal
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Sequencing FSM for a multicycle RV32I datapath. Steps each
//               instruction through fetch / decode / execute / memory /
//               writeback, driving the shared ALU selects, the shared
//               instruction/data memory port and the IR/PC/register-file
//               write enables.
// Ports       :
//   clk   in  : single clock, rising edge
//   rst_n in  : asynchronous active-low reset
//   bus       : multicycle_controller_if.master
//               in : op[6:0], branch_taken, mem_ready
//               out: mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
//                    ResultSrc[1:0], ALUSrcA[1:0], ALUSrcB[1:0], ALUOp[1:0],
//                    ImmSrc[2:0], instr_done, illegal
// Build option:
//   MC_ILLEGAL_TRAP_EN : when defined, an unknown opcode parks the FSM in a
//                        TRAP state with illegal=1 until reset. When
//                        undefined, an unknown opcode retires as a NOP and
//                        illegal is constant 0.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller (
  input  wire                            clk,
  input  wire                            rst_n,
  multicycle_controller_if.master        bus
);

  // --------------------------------------------------------------------------
  // Opcode and select encodings
  // --------------------------------------------------------------------------
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_I      = 7'b0010011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;

  localparam logic [2:0] c_IMM_I = 3'b000;
  localparam logic [2:0] c_IMM_S = 3'b001;
  localparam logic [2:0] c_IMM_B = 3'b010;
  localparam logic [2:0] c_IMM_J = 3'b011;
  localparam logic [2:0] c_IMM_U = 3'b100;

  localparam logic [1:0] c_RES_ALUOUT = 2'b00;
  localparam logic [1:0] c_RES_RDATA  = 2'b01;
  localparam logic [1:0] c_RES_ALU    = 2'b10;
  localparam logic [1:0] c_RES_IMM    = 2'b11;

  localparam logic [1:0] c_A_PC    = 2'b00;
  localparam logic [1:0] c_A_OLDPC = 2'b01;
  localparam logic [1:0] c_A_RS1   = 2'b10;

  localparam logic [1:0] c_B_RS2   = 2'b00;
  localparam logic [1:0] c_B_IMM   = 2'b01;
  localparam logic [1:0] c_B_FOUR  = 2'b10;

  localparam logic [1:0] c_ALU_IFN = 2'b00;
  localparam logic [1:0] c_ALU_BR  = 2'b01;
  localparam logic [1:0] c_ALU_RFN = 2'b10;
  localparam logic [1:0] c_ALU_ADD = 2'b11;

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXEC_R   = 4'd7,
    S_EXEC_I   = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_JALR     = 4'd12,
`ifdef MC_ILLEGAL_TRAP_EN
    S_TRAP     = 4'd14,
`endif
    S_LUI      = 4'd13
  } state_t;

  state_t     r_state;
  state_t     w_next;

  logic       w_mem_req;
  logic       w_adr_src;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_pc_write;
  logic       w_reg_write;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic [2:0] w_imm_src;
  logic [2:0] w_imm_dec;
  logic       w_instr_done;
  logic       w_illegal;

  // --------------------------------------------------------------------------
  // Immediate format from the opcode. R-type has no immediate, so it shares
  // the I encoding along with loads, JALR, OP-IMM and unknown opcodes.
  // --------------------------------------------------------------------------
  always_comb begin
    w_imm_dec = c_IMM_I;
    case (bus.op)
      c_OP_STORE:  w_imm_dec = c_IMM_S;
      c_OP_BRANCH: w_imm_dec = c_IMM_B;
      c_OP_JAL:    w_imm_dec = c_IMM_J;
      c_OP_LUI:    w_imm_dec = c_IMM_U;
      default:     w_imm_dec = c_IMM_I;
    endcase
  end

  // --------------------------------------------------------------------------
  // State register. Async reset forces RST, whose outputs are all zero, so a
  // pending memory request is withdrawn as soon as rst_n falls.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RST;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_next       = r_state;
    w_mem_req    = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_result_src = c_RES_ALUOUT;
    w_alu_src_a  = c_A_PC;
    w_alu_src_b  = c_B_RS2;
    w_alu_op     = c_ALU_IFN;
    w_imm_src    = w_imm_dec;
    w_instr_done = 1'b0;
    w_illegal    = 1'b0;

    case (r_state)
      S_RST: begin
        w_imm_src = c_IMM_I;
        w_next    = S_FETCH;
      end

      // IR and PC load on the same edge the memory returns the instruword;
      // the ALU is already producing PC+4 for the PC write.
      S_FETCH: begin
        w_imm_src    = c_IMM_I;
        w_mem_req    = 1'b1;
        w_adr_src    = 1'b0;
        w_alu_src_a  = c_A_PC;
        w_alu_src_b  = c_B_FOUR;
        w_alu_op     = c_ALU_ADD;
        w_result_src = c_RES_ALU;
        w_ir_write   = bus.mem_ready;
        w_pc_write   = bus.mem_ready;
        if (bus.mem_ready) begin
          w_next = S_DECODE;
        end
      end

      // OldPC + imm lands in ALUOut here, ready for a taken branch or JAL.
      S_DECODE: begin
        w_alu_src_a = c_A_OLDPC;
        w_alu_src_b = c_B_IMM;
        w_alu_op    = c_ALU_ADD;
        case (bus.op)
          c_OP_LOAD,
          c_OP_STORE:  w_next = S_MEMADR;
          c_OP_R:      w_next = S_EXEC_R;
          c_OP_I:      w_next = S_EXEC_I;
          c_OP_BRANCH: w_next = S_BRANCH;
          c_OP_JAL:    w_next = S_JAL;
          c_OP_JALR:   w_next = S_JALR;
          c_OP_LUI:    w_next = S_LUI;
          default: begin
`ifdef MC_ILLEGAL_TRAP_EN
            w_next = S_TRAP;
`else
            // PC has already advanced in FETCH, so retiring here is a NOP.
            w_instr_done = 1'b1;
            w_next       = S_FETCH;
`endif
          end
        endcase
      end

      S_MEMADR: begin
        w_alu_src_a = c_A_RS1;
        w_alu_src_b = c_B_IMM;
        w_alu_op    = c_ALU_ADD;
        w_next      = (bus.op == c_OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end

      S_MEMREAD: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
        if (bus.mem_ready) begin
          w_next = S_MEMWB;
        end
      end

      S_MEMWB: begin
        w_result_src = c_RES_RDATA;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end

      // A store retires on the edge that completes the write.
      S_MEMWRITE: begin
        w_mem_req    = 1'b1;
        w_adr_src    = 1'b1;
        w_mem_write  = 1'b1;
        w_instr_done = bus.mem_ready;
        if (bus.mem_ready) begin
          w_next = S_FETCH;
        end
      end

      S_EXEC_R: begin
        w_alu_src_a = c_A_RS1;
        w_alu_src_b = c_B_RS2;
        w_alu_op    = c_ALU_RFN;
        w_next      = S_ALUWB;
      end

      S_EXEC_I: begin
        w_alu_src_a = c_A_RS1;
        w_alu_src_b = c_B_IMM;
        w_alu_op    = c_ALU_IFN;
        w_next      = S_ALUWB;
      end

      S_ALUWB: begin
        w_result_src = c_RES_ALUOUT;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end

      // ALUOut still holds the target from DECODE; the ALU itself is busy
      // with the compare.
      S_BRANCH: begin
        w_alu_src_a  = c_A_RS1;
        w_alu_src_b  = c_B_RS2;
        w_alu_op     = c_ALU_BR;
        w_result_src = c_RES_ALUOUT;
        w_pc_write   = bus.branch_taken;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end

      // PC takes the target from ALUOut while the ALU forms the link value
      // OldPC+4, which ALUWB then writes to rd. Shared by JAL and JALR.
      S_JAL: begin
        w_result_src = c_RES_ALUOUT;
        w_pc_write   = 1'b1;
        w_alu_src_a  = c_A_OLDPC;
        w_alu_src_b  = c_B_FOUR;
        w_alu_op     = c_ALU_ADD;
        w_next       = S_ALUWB;
      end

      // rs1+imm is captured in ALUOut before rd is touched, so rd==rs1 works.
      S_JALR: begin
        w_alu_src_a = c_A_RS1;
        w_alu_src_b = c_B_IMM;
        w_alu_op    = c_ALU_ADD;
        w_next      = S_JAL;
      end

      S_LUI: begin
        w_result_src = c_RES_IMM;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end

`ifdef MC_ILLEGAL_TRAP_EN
      // Parked until reset; only the flag is visible.
      S_TRAP: begin
        w_imm_src = c_IMM_I;
        w_illegal = 1'b1;
        w_next    = S_TRAP;
      end
`endif

      default: begin
        w_imm_src = c_IMM_I;
        w_next    = S_RST;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output drive
  // --------------------------------------------------------------------------
  assign bus.mem_req    = w_mem_req;
  assign bus.AdrSrc     = w_adr_src;
  assign bus.MemWrite   = w_mem_write;
  assign bus.IRWrite    = w_ir_write;
  assign bus.PCWrite    = w_pc_write;
  assign bus.RegWrite   = w_reg_write;
  assign bus.ResultSrc  = w_result_src;
  assign bus.ALUSrcA    = w_alu_src_a;
  assign bus.ALUSrcB    = w_alu_src_b;
  assign bus.ALUOp      = w_alu_op;
  assign bus.ImmSrc     = w_imm_src;
  assign bus.instr_done = w_instr_done;
  assign bus.illegal    = w_illegal;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Self-checking bench for multicycle_controller. Per-cycle
//               output words are compared against a vector table; retire
//               latency is checked by a scoreboard of expected cycle counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int sb_q[$];

  // {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, ResultSrc,
  //  ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done, illegal}
  typedef logic [18:0] word_t;

  typedef struct {
    string              name;
    logic [6:0]         op;
    logic               taken;
    int                 n;
    logic [9:0]         mr;
    logic [9:0][18:0]   exp;
  } vec_t;

  vec_t vecs[$];

  function automatic word_t w(bit mreq, bit adr, bit mw, bit irw, bit pcw, bit rw,
                              bit [1:0] rs, bit [1:0] a, bit [1:0] b, bit [1:0] aop,
                              bit [2:0] imm, bit done, bit ill);
    return {mreq, adr, mw, irw, pcw, rw, rs, a, b, aop, imm, done, ill};
  endfunction

  function automatic word_t actual();
    return {bus.mem_req, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.PCWrite,
            bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
            bus.ImmSrc, bus.instr_done, bus.illegal};
  endfunction

  // Expected words per controller step, straight from the output tables.
  function automatic word_t e_fetch(bit mr);      return w(1,0,0,mr,mr,0,2'b10,2'b00,2'b10,2'b11,3'b000,0,0); endfunction
  function automatic word_t e_dec(bit [2:0] i, bit d); return w(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b11,i,d,0); endfunction
  function automatic word_t e_memadr(bit [2:0] i); return w(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b11,i,0,0); endfunction
  function automatic word_t e_memread();          return w(1,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0); endfunction
  function automatic word_t e_memwb();            return w(0,0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,1,0); endfunction
  function automatic word_t e_memwrite(bit mr);   return w(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b001,mr,0); endfunction
  function automatic word_t e_exec_r();           return w(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b000,0,0); endfunction
  function automatic word_t e_exec_i();           return w(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0); endfunction
  function automatic word_t e_aluwb(bit [2:0] i); return w(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,i,1,0); endfunction
  function automatic word_t e_branch(bit t);      return w(0,0,0,0,t,0,2'b00,2'b10,2'b00,2'b01,3'b010,1,0); endfunction
  function automatic word_t e_jal(bit [2:0] i);   return w(0,0,0,0,1,0,2'b00,2'b01,2'b10,2'b11,i,0,0); endfunction
  function automatic word_t e_jalr();             return w(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b11,3'b000,0,0); endfunction
  function automatic word_t e_lui();              return w(0,0,0,0,0,1,2'b11,2'b00,2'b00,2'b00,3'b100,1,0); endfunction
  function automatic word_t e_trap();             return w(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,1); endfunction

  task automatic check(input string nm, input int k, input word_t exp);
    word_t act;
    act = actual();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %05h expected %05h", nm, k, act, exp);
    end
  endtask

  // Called just after a rising edge; leaves just after a rising edge.
  task automatic run_vec(input vec_t v, input bit retire);
    if (retire) sb_q.push_back(v.n);
    for (int k = 0; k < v.n; k++) begin
      bus.op           = v.op;
      bus.branch_taken = (v.op == 7'b1100011) ? v.taken : 1'($urandom_range(0, 1));
      bus.mem_ready    = v.mr[k];
      @(negedge clk);
      check(v.name, k, v.exp[k]);
      @(posedge clk);
      #1;
    end
  endtask

  // Called away from an edge; drops reset, checks the immediate effect,
  // then releases and checks the RST cycle.
  task automatic pulse_reset(input string nm);
    rst_n = 1'b0;
    #1;
    check(nm, 0, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check(nm, 1, '0);
    @(posedge clk);
    #1;
  endtask

  // Retire monitor: counts cycles from FETCH entry to instr_done.
  int  mon_cyc = 0;
  bit  mon_rst = 1'b1;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mon_rst = 1'b1;
      mon_cyc = 0;
    end else if (mon_rst) begin
      mon_rst = 1'b0;
      mon_cyc = 0;
    end else begin
      mon_cyc++;
      if (bus.instr_done === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL retire: unexpected instr_done after %0d cycles, expected none", mon_cyc);
        end else begin
          int e;
          e = sb_q.pop_front();
          if (mon_cyc != e) begin
            errors++;
            $display("FAIL retire_latency: got %0d cycles expected %0d", mon_cyc, e);
          end
        end
        mon_cyc = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;

    // ---------------- vector table ----------------
    v = '{name:"R",   op:7'b0110011, taken:0, n:4, mr:'1, exp:'0};
    v.exp[0]=e_fetch(1); v.exp[1]=e_dec(3'b000,0); v.exp[2]=e_exec_r(); v.exp[3]=e_aluwb(3'b000);
    vecs.push_back(v);

    v = '{name:"I",   op:7'b0010011, taken:0, n:4, mr:'1, exp:'0};
    v.exp[0]=e_fetch(1); v.exp[1]=e_dec(3'b000,0); v.exp[2]=e_exec_i(); v.exp[3]=e_aluwb(3'b000);
    vecs.push_back(v);

    v = '{name:"LOAD", op:7'b0000011, taken:0, n:5, mr:'1, exp:'0};
    v.exp[0]=e_fetch(1); v.exp[1]=e_dec(3'b000,0); v.exp[2]=e_memadr(3'b000);
    v.exp[3]=e_memread(); v.exp[4]=e_memwb();
    vecs.push_back(v);

    v = '{name:"STORE", op:7'b0100011, taken:0, n:4, mr:'1, exp:'0};
    v.exp[0]=e_fetch(1); v.exp[1]=e_dec(3'b001,0); v.exp[2]=e_memadr(3'b001); v.exp[3]=e_memwrite(1);
    vecs.push_back(v);

    v = '{name:"LUI", op:7'b0110111, taken:0, n:3, mr:'1, exp:'0};
    v.exp[0]=e_fetch(1); v.exp[1]=e_dec(3'b100,0); v.exp[2]=e_lui();
    vecs.push_back(v);

    v = '{name:"BR_T", op:7'b1100011, taken:1, n:3, mr:'1, exp:'0};
    v.exp[0]=e_fetch(1); v.exp[1]=e_dec(3'b010,0); v.exp[2]=e_branch(1);
    vecs.push_back(v);

    v = '{name:"BR_NT", op:7'b1100011, taken:0, n:3, mr:'1, exp:'0};
    v.exp[0]=e_fetch(1); v.exp[1]=e_dec(3'b010,0); v.exp[2]=e_branch(0);
    vecs.push_back(v);

    v = '{name:"JAL", op:7'b1101111, taken:0, n:4, mr:'1, exp:'0};
    v.exp[0]=e_fetch(1); v.exp[1]=e_dec(3'b011,0); v.exp[2]=e_jal(3'b011); v.exp[3]=e_aluwb(3'b011);
    vecs.push_back(v);

    v = '{name:"JALR", op:7'b1100111, taken:0, n:5, mr:'1, exp:'0};
    v.exp[0]=e_fetch(1); v.exp[1]=e_dec(3'b000,0); v.exp[2]=e_jalr();
    v.exp[3]=e_jal(3'b000); v.exp[4]=e_aluwb(3'b000);
    vecs.push_back(v);

    v = '{name:"R_FWAIT", op:7'b0110011, taken:0, n:5, mr:10'b1111111110, exp:'0};
    v.exp[0]=e_fetch(0); v.exp[1]=e_fetch(1); v.exp[2]=e_dec(3'b000,0);
    v.exp[3]=e_exec_r(); v.exp[4]=e_aluwb(3'b000);
    vecs.push_back(v);

    v = '{name:"ST_WAIT", op:7'b0100011, taken:0, n:6, mr:10'b1111100111, exp:'0};
    v.exp[0]=e_fetch(1); v.exp[1]=e_dec(3'b001,0); v.exp[2]=e_memadr(3'b001);
    v.exp[3]=e_memwrite(0); v.exp[4]=e_memwrite(0); v.exp[5]=e_memwrite(1);
    vecs.push_back(v);

    // ---------------- reset ----------------
    rst_n            = 1'b0;
    bus.op           = 7'b0;
    bus.branch_taken = 1'b0;
    bus.mem_ready    = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("reset", 0, '0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_cycle", 0, '0);
    @(posedge clk);
    #1;

    // ---------------- table ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], 1'b1);
    end

    // ---------------- load with stalls: 2 in FETCH, 3 in MEMREAD ----------------
    v = '{name:"LOAD_STALL", op:7'b0000011, taken:0, n:10, mr:10'b1100011100, exp:'0};
    v.exp[0]=e_fetch(0); v.exp[1]=e_fetch(0); v.exp[2]=e_fetch(1);
    v.exp[3]=e_dec(3'b000,0); v.exp[4]=e_memadr(3'b000);
    v.exp[5]=e_memread(); v.exp[6]=e_memread(); v.exp[7]=e_memread(); v.exp[8]=e_memread();
    v.exp[9]=e_memwb();
    run_vec(v, 1'b1);

    // ---------------- unknown opcode ----------------
`ifdef MC_ILLEGAL_TRAP_EN
    v = '{name:"ILL_ENTRY", op:7'b0000000, taken:0, n:2, mr:'1, exp:'0};
    v.exp[0]=e_fetch(1); v.exp[1]=e_dec(3'b000,0);
    run_vec(v, 1'b0);
    for (int k = 0; k < 20; k++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("TRAP", k, e_trap());
      @(posedge clk);
      #1;
    end
    pulse_reset("trap_reset");
`else
    v = '{name:"ILL_NOP", op:7'b0000000, taken:0, n:2, mr:'1, exp:'0};
    v.exp[0]=e_fetch(1); v.exp[1]=e_dec(3'b000,1);
    run_vec(v, 1'b1);
`endif
    // Next instruction must start cleanly in FETCH.
    run_vec(vecs[4], 1'b1);

    // ---------------- reset during MEMREAD ----------------
    v = '{name:"LOAD_ABORT", op:7'b0000011, taken:0, n:3, mr:'1, exp:'0};
    v.exp[0]=e_fetch(1); v.exp[1]=e_dec(3'b000,0); v.exp[2]=e_memadr(3'b000);
    run_vec(v, 1'b0);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check("LOAD_ABORT_MEMREAD", 3, e_memread());
    pulse_reset("memread_reset");
    run_vec(vecs[0], 1'b1);

    // ---------------- wrap up ----------------
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending retirements expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
